// File: rtl/sort_host_if.sv
// Stream and sorter-pin bundle for sort_host: input byte stream, sorted output
// stream, status flags and the sorter's start/addr/wr/datain/dataout/ready pins.
interface sort_host_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              err;
  logic              srt_start;
  logic [ADDR_W-1:0] srt_addr;
  logic              srt_wr;
  logic [DATA_W-1:0] srt_datain;
  logic [DATA_W-1:0] srt_dataout;
  logic              srt_ready;

  // Host side: drives the sorter pins and both stream handshakes' outputs.
  modport master (
    input  in_valid, in_data, out_ready, srt_dataout, srt_ready,
    output in_ready, out_valid, out_data, busy, err,
           srt_start, srt_addr, srt_wr, srt_datain
  );

  // Environment side: byte source, byte sink and the sorter itself.
  modport slave (
    output in_valid, in_data, out_ready, srt_dataout, srt_ready,
    input  in_ready, out_valid, out_data, busy, err,
           srt_start, srt_addr, srt_wr, srt_datain
  );
endinterface

// File: rtl/sort_host.sv
// Stream front-end for the 8-entry byte sorter: load 8 bytes, kick, wait, read back.
// Optional sorter-completion watchdog enabled by defining SORT_HOST_TIMEOUT_EN.
module sort_host #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  sort_host_if.master bus
);
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_KICK  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RCAP  = 3'd4;
  localparam logic [2:0] S_EMIT  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("sort_host: TIMEOUT must be at least 1");
  end

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_tmo_hit;

`ifdef SORT_HOST_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             r_err;

  // Watchdog counts WAIT cycles; cleared in KICK so it starts at 0 on WAIT entry.
  always_comb begin
    w_tmo_nxt = r_tmo;
    if (r_state == S_KICK) begin
      w_tmo_nxt = '0;
    end else if (r_state == S_WAIT) begin
      w_tmo_nxt = r_tmo + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_WAIT) && !bus.srt_ready &&
                     (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_tmo_nxt;
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_LOAD;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out_data <= w_out_data_nxt;
    end
  end

  // Sorter pins are combinational so a load handshake writes in its own cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_out_data_nxt = r_out_data;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.srt_start  = 1'b0;
    bus.srt_wr     = 1'b0;
    bus.srt_addr   = r_cnt;
    bus.srt_datain = '0;

    case (r_state)
      S_LOAD: begin
        bus.in_ready = bus.srt_ready;
        if (bus.in_valid && bus.srt_ready) begin
          bus.srt_wr     = 1'b1;
          bus.srt_datain = bus.in_data;
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) w_state_nxt = S_KICK;
        end
      end
      S_KICK: begin
        bus.srt_start = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        bus.srt_addr = '0;
        if (bus.srt_ready) begin
          w_state_nxt = S_RADDR;
          w_cnt_nxt   = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_RADDR: begin
        w_state_nxt = S_RCAP;
      end
      S_RCAP: begin
        w_out_data_nxt = bus.srt_dataout;
        w_state_nxt    = S_EMIT;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = (r_cnt == CNT_LAST) ? S_LOAD : S_RADDR;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.out_data = r_out_data;
  assign bus.busy     = !((r_state == S_LOAD) && (r_cnt == '0));

endmodule
